// File: rtl/avl_st_pkt_gen_param.sv
// Parametrised Avalon-ST packet generator with an Avalon-MM CSR block.
// Emits PKT_NUM packets (or runs continuously) of PKT_LEN bytes, with an
// inter-packet gap of IPG idle cycles. Payload byte k = SEED + k (mod 256).
// Keeps 32-bit packet and byte counters.
module avl_st_pkt_gen_param #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int LEN_W   = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         csr_address,
    input  logic               csr_read,
    input  logic               csr_write,
    input  logic [31:0]        csr_writedata,
    output logic [31:0]        csr_readdata,
    output logic               csr_waitrequest,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_valid,
    output logic               tx_sop,
    output logic               tx_eop,
    output logic [EMPTY_W-1:0] tx_empty,
    output logic               tx_error,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done
);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
    state_t state_q, state_d;

    // Programmable configuration, as seen by CSR reads
    logic [31:0]      num_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       ipg_q, seed_q;
    logic             cont_q;

    // Configuration captured at start; the run only uses these
    logic [31:0]      num_s_q;
    logic [LEN_W-1:0] len_s_q;
    logic [7:0]       ipg_s_q, seed_s_q;
    logic             cont_s_q;

    logic [LEN_W-1:0] beat_q, beat_d;
    logic [31:0]      sent_q, sent_d;
    logic [7:0]       gap_q, gap_d;
    logic             stop_pend_q, stop_pend_d;
    logic             err_arm_q, err_arm_d;
    logic             done_q, done_d;
    logic [31:0]      pkt_cnt_q, byte_cnt_q;
    logic             rd_pend_q;
    logic [31:0]      rdata_q, rd_mux;

    // CTRL write-one strobes
    logic ctrl_wr, start_wr, stop_wr, clr_wr, inj_wr;
    assign ctrl_wr  = csr_write && (csr_address == 3'd0);
    assign start_wr = ctrl_wr && csr_writedata[0];
    assign stop_wr  = ctrl_wr && csr_writedata[1];
    assign clr_wr   = ctrl_wr && csr_writedata[3];
    assign inj_wr   = ctrl_wr && csr_writedata[4];

    // Beat geometry: byte offset of this beat and whether it covers the end
    logic [31:0] off, end_off, len32;
    logic        last_beat, acc, acc_eop;
    assign len32     = {{(32-LEN_W){1'b0}}, len_s_q};
    assign off       = 32'(beat_q) * 32'(BYTES);
    assign end_off   = off + 32'(BYTES);
    assign last_beat = (end_off >= len32);

    assign tx_valid = (state_q == S_SEND);
    assign acc      = tx_valid && tx_ready;
    assign acc_eop  = acc && last_beat;

    // Outputs depend only on registered state, so they hold under backpressure
    assign tx_sop   = tx_valid && (beat_q == '0);
    assign tx_eop   = tx_valid && last_beat;
    assign tx_empty = tx_eop ? EMPTY_W'(end_off - len32) : '0;
    assign tx_error = tx_eop && err_arm_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    // First byte of the packet sits in the most significant lane
    for (genvar j = 0; j < BYTES; j++) begin : g_byte
        logic [31:0] k;
        assign k = off + 32'(j);
        assign tx_data[DATA_W-1-8*j -: 8] = (tx_valid && (k < len32)) ? seed_s_q + k[7:0] : 8'd0;
    end

    // Next-state logic for the IDLE/SEND/GAP sequencer
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        sent_d      = sent_q;
        gap_d       = gap_q;
        stop_pend_d = stop_pend_q;
        done_d      = done_q;
        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    stop_pend_d = 1'b0;
                    if ((num_q == 32'd0) && !csr_writedata[2]) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        beat_d  = '0;
                        sent_d  = '0;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (stop_wr) stop_pend_d = 1'b1;
                if (acc) begin
                    if (last_beat) begin
                        beat_d = '0;
                        sent_d = sent_q + 32'd1;
                        if (stop_pend_q || stop_wr || (!cont_s_q && (sent_q + 32'd1 == num_s_q))) begin
                            state_d     = S_IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (ipg_s_q != 8'd0) begin
                            state_d = S_GAP;
                            gap_d   = ipg_s_q;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (stop_wr) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == 8'd1) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh inj_err arms even if an eop is consuming the previous arm
    always_comb begin
        err_arm_d = err_arm_q;
        if (acc_eop && err_arm_q) err_arm_d = 1'b0;
        if (inj_wr) err_arm_d = 1'b1;
    end

    // Sequencer, counter and run-shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            sent_q      <= '0;
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            err_arm_q   <= 1'b0;
            done_q      <= 1'b0;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            num_s_q     <= '0;
            len_s_q     <= '0;
            ipg_s_q     <= '0;
            seed_s_q    <= '0;
            cont_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            sent_q      <= sent_d;
            gap_q       <= gap_d;
            stop_pend_q <= stop_pend_d;
            err_arm_q   <= err_arm_d;
            done_q      <= done_d;
            if (clr_wr) begin
                pkt_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else if (acc_eop) begin
                pkt_cnt_q  <= pkt_cnt_q + 32'd1;
                byte_cnt_q <= byte_cnt_q + len32;
            end
            if ((state_q == S_IDLE) && start_wr) begin
                num_s_q  <= num_q;
                len_s_q  <= (len_q == '0) ? LEN_W'(1) : len_q;
                ipg_s_q  <= ipg_q;
                seed_s_q <= seed_q;
                cont_s_q <= csr_writedata[2];
            end
        end
    end

    // CSR configuration writes, zero wait states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q  <= 32'd1;
            len_q  <= LEN_W'(64);
            ipg_q  <= 8'd12;
            seed_q <= 8'd0;
            cont_q <= 1'b0;
        end else if (csr_write) begin
            case (csr_address)
                3'd0:    cont_q <= csr_writedata[2];
                3'd1:    num_q  <= csr_writedata;
                3'd2:    len_q  <= csr_writedata[LEN_W-1:0];
                3'd3:    ipg_q  <= csr_writedata[7:0];
                3'd4:    seed_q <= csr_writedata[7:0];
                default: ;
            endcase
        end
    end

    // CSR read decode; unmapped bits read 0
    always_comb begin
        rd_mux = 32'd0;
        case (csr_address)
            3'd0: rd_mux = {29'd0, cont_q, 2'd0};
            3'd1: rd_mux = num_q;
            3'd2: rd_mux = {{(32-LEN_W){1'b0}}, len_q};
            3'd3: rd_mux = {24'd0, ipg_q};
            3'd4: rd_mux = {24'd0, seed_q};
            3'd5: rd_mux = {30'd0, done_q, busy};
            3'd6: rd_mux = pkt_cnt_q;
            3'd7: rd_mux = byte_cnt_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Reads take two cycles: stall in the first while readdata is registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= csr_read && !rd_pend_q;
            if (csr_read && !rd_pend_q) rdata_q <= rd_mux;
        end
    end

    assign csr_waitrequest = csr_read && !rd_pend_q;
    assign csr_readdata    = rdata_q;
endmodule

// File: tb/tb_avl_st_pkt_gen_param.sv
// Bench for avl_st_pkt_gen_param: a byte-stream model checks every valid beat
// of the 64-bit instance; a 128-bit instance shares the CSR bus for the
// wide-datapath checks.
`timescale 1ns/1ps
module tb_avl_st_pkt_gen_param;
    localparam int DW    = 64;
    localparam int BYTES = DW / 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   csr_address = 3'd0;
    logic         csr_read = 1'b0, csr_write = 1'b0;
    logic [31:0]  csr_writedata = 32'd0;
    logic [31:0]  rdata, rdata2;
    logic         wait_r, wait_r2;
    logic [63:0]  tx_data;
    logic         tx_valid, tx_sop, tx_eop, tx_error, busy, done;
    logic [2:0]   tx_empty;
    logic [127:0] tx_data2;
    logic         tx_valid2, tx_sop2, tx_eop2, tx_error2, busy2, done2;
    logic [3:0]   tx_empty2;
    logic         tx_ready = 1'b1;

    int n_tests = 0, n_fail = 0;

    // Model state
    int exp_len = 1, exp_seed = 0, exp_ipg = 0, exp_err_pkt = -1;
    int m_off = 0, run_pkt = 0, gap_run = 0, gap_last = 0, err_seen = 0;
    int beats_run = 0, m_beats_total = 0, tot_pkt = 0, tot_bytes = 0, last_empty = 0;
    logic [63:0] first_data, last_data;
    logic [69:0] snap;
    bit stall = 0;

    always #5 clk = ~clk;

    avl_st_pkt_gen_param #(.DATA_W(64), .EMPTY_W(3), .LEN_W(14)) u_dut (
        .clk(clk), .reset(reset), .csr_address(csr_address), .csr_read(csr_read),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(rdata),
        .csr_waitrequest(wait_r), .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop),
        .tx_eop(tx_eop), .tx_empty(tx_empty), .tx_error(tx_error), .tx_ready(tx_ready),
        .busy(busy), .done(done));

    avl_st_pkt_gen_param #(.DATA_W(128), .EMPTY_W(4), .LEN_W(14)) u_dut128 (
        .clk(clk), .reset(reset), .csr_address(csr_address), .csr_read(csr_read),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(rdata2),
        .csr_waitrequest(wait_r2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_sop(tx_sop2),
        .tx_eop(tx_eop2), .tx_empty(tx_empty2), .tx_error(tx_error2), .tx_ready(tx_ready),
        .busy(busy2), .done(done2));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1; #1;
        check("rd_wait_first", 128'(wait_r), 128'(1));
        @(posedge clk); #1;
        check("rd_wait_second", 128'(wait_r), 128'(0));
        d = rdata;
        @(posedge clk); #1;
        csr_read = 1'b0;
    endtask

    task automatic chk_csr(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(a, d);
        check(name, 128'(d), 128'(exp));
    endtask

    task automatic start_run(input int len, input int seed, input int ipg, input int errp,
                             input logic [31:0] ctrl);
        exp_len = (len == 0) ? 1 : len; exp_seed = seed; exp_ipg = ipg; exp_err_pkt = errp;
        run_pkt = 0; m_off = 0; gap_run = 0; err_seen = 0; beats_run = 0;
        csr_wr(3'd0, ctrl);
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        for (int i = 0; i < maxc && !done; i++) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        check("wait_done", 128'(done), 128'(1));
    endtask

    // Byte-stream model: each accepted beat consumes BYTES payload bytes
    always @(negedge clk) begin
        logic [63:0] ed;
        logic        eeop, eerr;
        int          ee, k;
        bit          ok;
        if (reset) begin
            m_off = 0; stall = 0;
        end else if (tx_valid) begin
            for (int j = 0; j < BYTES; j++) begin
                k = m_off + j;
                ed[DW-1-8*j -: 8] = (k < exp_len) ? 8'(exp_seed + k) : 8'h00;
            end
            eeop = (m_off + BYTES >= exp_len);
            ee   = eeop ? (m_off + BYTES - exp_len) : 0;
            eerr = eeop && (run_pkt == exp_err_pkt);
            ok = (tx_data == ed) && (tx_sop == (m_off == 0)) && (tx_eop == eeop) &&
                 (tx_empty == 3'(ee)) && (tx_error == eerr);
            if (stall && ({tx_data, tx_sop, tx_eop, tx_empty, tx_error} != snap)) ok = 0;
            if (m_off == 0 && run_pkt > 0 && gap_run != exp_ipg) ok = 0;
            if (m_off == 0) begin
                gap_last = gap_run;
                first_data = tx_data;
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL beat pkt%0d off%0d: data=%h sop=%b eop=%b empty=%0d err=%b gap=%0d stall=%b; want data=%h eop=%b empty=%0d err=%b gap=%0d",
                         run_pkt, m_off, tx_data, tx_sop, tx_eop, tx_empty, tx_error, gap_run, stall,
                         ed, eeop, ee, eerr, exp_ipg);
            end
            stall = !tx_ready;
            snap  = {tx_data, tx_sop, tx_eop, tx_empty, tx_error};
            if (tx_ready) begin
                beats_run++; m_beats_total++;
                if (eeop) begin
                    last_data = tx_data; last_empty = int'(tx_empty);
                    if (tx_error) err_seen++;
                    run_pkt++; tot_pkt++; tot_bytes += exp_len;
                    m_off = 0; gap_run = 0;
                end else begin
                    m_off += BYTES;
                end
            end
        end else begin
            gap_run++;
            stall = 0;
        end
    end

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_tx", 128'({tx_valid, tx_sop, tx_eop, tx_empty, tx_error, busy, done, tx_data}), 128'(0));
        chk_csr("rst_num", 3'd1, 32'd1);
        chk_csr("rst_len", 3'd2, 32'd64);
        chk_csr("rst_ipg", 3'd3, 32'd12);
        chk_csr("rst_seed", 3'd4, 32'd0);
        chk_csr("rst_status", 3'd5, 32'd0);
        chk_csr("rst_pktcnt", 3'd6, 32'd0);

        // T1: 3 x 64-byte packets back to back
        csr_wr(3'd1, 32'd3); csr_wr(3'd3, 32'd0);
        start_run(64, 0, 0, -1, 32'h1);
        wait_done(200, 0);
        check("t1_beats", 128'(beats_run), 128'(24));
        check("t1_model_pkts", 128'(tot_pkt), 128'(3));
        check("t1_model_bytes", 128'(tot_bytes), 128'(192));
        chk_csr("t1_pktcnt", 3'd6, 32'(tot_pkt));
        chk_csr("t1_bytecnt", 3'd7, 32'(tot_bytes));
        chk_csr("t1_status", 3'd5, 32'd2);

        // T2: 61 bytes, seed F0
        csr_wr(3'd2, 32'd61); csr_wr(3'd1, 32'd1); csr_wr(3'd4, 32'hF0);
        start_run(61, 'hF0, 0, -1, 32'h1);
        wait_done(100, 0);
        check("t2_first", 128'(first_data), 128'(64'hF0F1F2F3F4F5F6F7));
        check("t2_last", 128'(last_data), 128'(64'h28292A2B2C000000));
        check("t2_empty", 128'(last_empty), 128'(3));
        check("t2_beats", 128'(beats_run), 128'(8));

        // T3: 100 bytes under random backpressure
        csr_wr(3'd2, 32'd100); csr_wr(3'd4, 32'h10);
        start_run(100, 'h10, 0, -1, 32'h1);
        wait_done(600, 1);
        check("t3_beats", 128'(beats_run), 128'(13));
        check("t3_empty", 128'(last_empty), 128'(4));
        check("t3_last", 128'(last_data), 128'(64'h7071727300000000));
        chk_csr("t3_bytecnt", 3'd7, 32'(tot_bytes));

        // T4: continuous with IPG 5, stop during packet 2
        csr_wr(3'd2, 32'd16); csr_wr(3'd3, 32'd5);
        start_run(16, 'h10, 5, -1, 32'h5);
        for (int i = 0; i < 200; i++) begin
            if (tx_valid && tx_sop && run_pkt == 1) break;
            @(posedge clk); #1;
        end
        csr_wr(3'd0, 32'h2);
        wait_done(100, 0);
        repeat (20) @(posedge clk);
        #1;
        check("t4_pkts", 128'(run_pkt), 128'(2));
        check("t4_gap", 128'(gap_last), 128'(5));
        check("t4_busy_done", 128'({busy, done}), 128'(2'b01));

        // T4b: stop while in the gap ends the run at once
        start_run(16, 'h10, 5, -1, 32'h5);
        for (int i = 0; i < 100; i++) begin
            if (run_pkt == 1) break;
            @(posedge clk); #1;
        end
        csr_wr(3'd0, 32'h2);
        check("t4b_busy_done", 128'({busy, done}), 128'(2'b01));
        repeat (10) @(posedge clk);
        #1;
        check("t4b_pkts", 128'(run_pkt), 128'(1));

        // T5: error injection on packet 1 of 2
        csr_wr(3'd0, 32'h10);
        csr_wr(3'd1, 32'd2); csr_wr(3'd2, 32'd8); csr_wr(3'd3, 32'd3); csr_wr(3'd4, 32'h33);
        start_run(8, 'h33, 3, 0, 32'h1);
        wait_done(100, 0);
        check("t5_err_count", 128'(err_seen), 128'(1));
        check("t5_pkts", 128'(run_pkt), 128'(2));
        // clr_cnt in the same cycle as an accepted eop
        csr_wr(3'd1, 32'd1); csr_wr(3'd4, 32'h44);
        tx_ready = 1'b0;
        start_run(8, 'h44, 3, -1, 32'h1);
        for (int i = 0; i < 20 && !tx_valid; i++) begin
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        csr_wr(3'd0, 32'h8);
        wait_done(20, 0);
        check("t5_clr_pkt_seen", 128'(run_pkt), 128'(1));
        chk_csr("t5_pktcnt_clr", 3'd6, 32'd0);
        chk_csr("t5_bytecnt_clr", 3'd7, 32'd0);
        tot_pkt = 0; tot_bytes = 0;

        // T6: NUM=0 completes without traffic on both widths
        csr_wr(3'd1, 32'd0); csr_wr(3'd2, 32'd1); csr_wr(3'd4, 32'h5A); csr_wr(3'd3, 32'd0);
        b0 = m_beats_total;
        start_run(1, 'h5A, 0, -1, 32'h1);
        @(posedge clk); #1;
        check("t6_num0_done", 128'({done, done2, busy, busy2, tx_valid2}), 128'(5'b11000));
        check("t6_num0_beats", 128'(m_beats_total), 128'(b0));
        // single-byte packet on the 128-bit datapath
        csr_wr(3'd1, 32'd1);
        start_run(1, 'h5A, 0, -1, 32'h1);
        check("t6_w128_flags", 128'({tx_valid2, tx_sop2, tx_eop2, tx_error2}), 128'(4'b1110));
        check("t6_w128_empty", 128'(tx_empty2), 128'(15));
        check("t6_w128_data", tx_data2, {8'h5A, 120'd0});
        wait_done(20, 0);
        check("t6_w64_empty", 128'(last_empty), 128'(7));
        // reset in the middle of a packet
        csr_wr(3'd2, 32'd64);
        tx_ready = 1'b0;
        start_run(64, 'h5A, 0, -1, 32'h1);
        @(posedge clk); #1;
        check("t6_pre_rst_valid", 128'({tx_valid, tx_valid2}), 128'(2'b11));
        reset = 1'b1; #1;
        check("t6_rst_async", 128'({tx_valid, tx_sop, tx_eop, tx_empty, tx_error, busy, done, tx_data}), 128'(0));
        @(posedge clk); #1;
        check("t6_rst_w128", 128'({tx_valid2, tx_sop2, tx_eop2, tx_empty2, tx_error2, busy2, done2}), 128'(0));
        check("t6_rst_data128", tx_data2, 128'(0));
        reset = 1'b0; tx_ready = 1'b1;
        @(posedge clk); #1;
        chk_csr("t6_rst_num", 3'd1, 32'd1);
        check("t6_post_rst_idle", 128'({tx_valid, busy, done}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
